spi_master_par: RTL and testbench

SPI_MASTER_PAR -- requirements
Module: spi_master_par

---
 rtl/spi_master_par.sv | 150 +++++++++++++++
 tb/tb_spi_master_par.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_par.sv
// SPI master: one parallel word per frame, MSB first, selectable chip select.
// Every output is a register loaded from the next-state values.
module spi_master_par #(
  parameter int   DATA_W = 16,
  parameter int   DIV    = 10,
  parameter int   N_CS   = 2,
  parameter logic CPOL   = 1'b0,
  parameter logic CPHA   = 1'b0,
  parameter int   CS_GAP = 2
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [DATA_W-1:0]                            idata,
  input  logic [((N_CS > 1) ? $clog2(N_CS) : 1)-1:0]   chan,
  input  logic                                         newTxData,
  input  logic                                         miso,
  output logic                                         mosi,
  output logic                                         sck,
  output logic [N_CS-1:0]                              ncs,
  output logic                                         txBusy,
  output logic [DATA_W-1:0]                            odata,
  output logic                                         newRxData
);

  localparam int CW      = (N_CS > 1) ? $clog2(N_CS) : 1;
  localparam int CNT_MAX = (DIV > CS_GAP) ? DIV : CS_GAP;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam int BITW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] HALF     = CNTW'(DIV / 2);
  localparam logic [CNTW-1:0] HALF_M1  = CNTW'(DIV / 2 - 1);
  localparam logic [CNTW-1:0] DIV_M1   = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0] GAP_M1   = CNTW'(CS_GAP - 1);
  localparam logic [BITW-1:0] BIT_ONE  = BITW'(1);
  localparam logic [BITW-1:0] LAST_BIT = BITW'(DATA_W - 1);
  localparam logic [CW:0]     NCS_L    = (CW + 1)'(N_CS);
  localparam logic [N_CS-1:0] CS_IDLE  = {N_CS{1'b1}};

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            r_state, w_state_n;
  logic [CNTW-1:0]   r_cnt, w_cnt_n;
  logic [BITW-1:0]   r_bit, w_bit_n;
  logic [DATA_W-1:0] r_tx, w_tx_n, r_rx, r_odata;
  logic [CW-1:0]     r_chan, w_chan_n;
  logic              w_start, w_load, w_rx_done, w_act;
  logic              r_mosi, r_sck, r_busy, r_nrx;
  logic [N_CS-1:0]   r_ncs;

  assign w_start = newTxData && ({1'b0, chan} < NCS_L);
  assign w_act   = CPHA ? (w_cnt_n < HALF) : (w_cnt_n >= HALF);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + CNT_ONE;
    w_bit_n   = r_bit;
    w_tx_n    = r_tx;
    w_chan_n  = r_chan;
    w_load    = 1'b0;
    w_rx_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        if (w_start) begin
          w_state_n = SETUP;
          w_load    = 1'b1;
        end
      end
      SETUP: if (r_cnt == HALF_M1) begin
        w_state_n = SHIFT;
        w_cnt_n   = '0;
        w_bit_n   = '0;
      end
      SHIFT: if (r_cnt == DIV_M1) begin
        w_cnt_n = '0;
        if (r_bit == LAST_BIT) begin
          w_state_n = HOLD;
        end else begin
          w_bit_n = r_bit + BIT_ONE;
          w_tx_n  = r_tx << 1;
        end
      end
      HOLD: if (r_cnt == HALF_M1) begin
        w_state_n = GAP;
        w_cnt_n   = '0;
        w_rx_done = 1'b1;
      end
      GAP: if (r_cnt == GAP_M1) begin
        // The last gap cycle doubles as the accept slot, so back-to-back
        // frames keep ncs high for exactly CS_GAP cycles.
        w_cnt_n = '0;
        if (w_start) begin
          w_state_n = SETUP;
          w_load    = 1'b1;
        end else begin
          w_state_n = IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
        w_bit_n   = '0;
      end
    endcase
    if (w_load) begin
      w_tx_n   = idata;
      w_chan_n = chan;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_mosi  <= 1'b1;
      r_sck   <= CPOL;
      r_ncs   <= CS_IDLE;
      r_busy  <= 1'b0;
      r_nrx   <= 1'b0;
      r_odata <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_busy  <= (w_state_n != IDLE);
      r_nrx   <= w_rx_done;
      if (w_rx_done) r_odata <= r_rx;
      r_sck   <= (w_state_n == SHIFT) ? (CPOL ^ w_act) : CPOL;
      r_mosi  <= (w_state_n inside {SETUP, SHIFT, HOLD}) ? w_tx_n[DATA_W-1] : 1'b1;
      r_ncs   <= (w_state_n inside {SETUP, SHIFT, HOLD}) ? ~(N_CS'(1) << w_chan_n) : CS_IDLE;
    end
  end

  // Shift registers and latched channel carry no reset; they are reloaded per frame.
  always_ff @(posedge clk) begin
    r_tx   <= w_tx_n;
    r_chan <= w_chan_n;
    if (r_state == SHIFT && r_cnt == HALF) r_rx <= (r_rx << 1) | DATA_W'(miso);
  end

  assign mosi      = r_mosi;
  assign sck       = r_sck;
  assign ncs       = r_ncs;
  assign txBusy    = r_busy;
  assign odata     = r_odata;
  assign newRxData = r_nrx;

endmodule

// File: tb/tb_spi_master_par.sv
// Bench for spi_master_par: four parameterisations observed through one mux,
// checked against an SPI-slave-level model of each frame.
module tb_spi_master_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic [31:0] d32   = '0;
  logic [1:0]  ch    = '0;
  logic [3:0]  req   = '0;
  logic        miso_drv = 1'b0, lb = 1'b0, miso_w;
  int          sel = 0;

  logic mosi0, sck0, busy0, nrx0; logic [1:0] ncs0; logic [15:0] od0;
  logic mosi1, sck1, busy1, nrx1; logic [1:0] ncs1; logic [15:0] od1;
  logic mosi2, sck2, busy2, nrx2; logic [1:0] ncs2; logic [11:0] od2;
  logic mosi3, sck3, busy3, nrx3; logic [2:0] ncs3; logic [7:0]  od3;

  spi_master_par dut0 (.clk(clk), .reset(reset), .idata(d32[15:0]), .chan(ch[0]),
    .newTxData(req[0]), .miso(miso_w), .mosi(mosi0), .sck(sck0), .ncs(ncs0),
    .txBusy(busy0), .odata(od0), .newRxData(nrx0));
  spi_master_par #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (.clk(clk), .reset(reset),
    .idata(d32[15:0]), .chan(ch[0]), .newTxData(req[1]), .miso(miso_w), .mosi(mosi1),
    .sck(sck1), .ncs(ncs1), .txBusy(busy1), .odata(od1), .newRxData(nrx1));
  spi_master_par #(.DATA_W(12), .DIV(4)) dut2 (.clk(clk), .reset(reset),
    .idata(d32[11:0]), .chan(ch[0]), .newTxData(req[2]), .miso(miso_w), .mosi(mosi2),
    .sck(sck2), .ncs(ncs2), .txBusy(busy2), .odata(od2), .newRxData(nrx2));
  spi_master_par #(.DATA_W(8), .DIV(6), .N_CS(3), .CPHA(1'b1), .CS_GAP(3)) dut3 (
    .clk(clk), .reset(reset), .idata(d32[7:0]), .chan(ch), .newTxData(req[3]),
    .miso(miso_w), .mosi(mosi3), .sck(sck3), .ncs(ncs3), .txBusy(busy3),
    .odata(od3), .newRxData(nrx3));

  int   p_dw   [4] = '{16, 16, 12, 8};
  int   p_div  [4] = '{10, 10, 4, 6};
  int   p_gap  [4] = '{2, 2, 2, 3};
  int   p_ncs  [4] = '{2, 2, 2, 3};
  logic p_cpol [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic p_cpha [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic o_mosi, o_sck, o_busy, o_nrx; logic [2:0] o_ncs; logic [31:0] o_od;
  always_comb begin
    o_mosi = mosi0; o_sck = sck0; o_busy = busy0; o_nrx = nrx0;
    o_ncs = {1'b1, ncs0}; o_od = {16'h0, od0};
    case (sel)
      1: begin o_mosi = mosi1; o_sck = sck1; o_busy = busy1; o_nrx = nrx1;
               o_ncs = {1'b1, ncs1}; o_od = {16'h0, od1}; end
      2: begin o_mosi = mosi2; o_sck = sck2; o_busy = busy2; o_nrx = nrx2;
               o_ncs = {1'b1, ncs2}; o_od = {20'h0, od2}; end
      3: begin o_mosi = mosi3; o_sck = sck3; o_busy = busy3; o_nrx = nrx3;
               o_ncs = ncs3; o_od = {24'h0, od3}; end
      default: ;
    endcase
  end
  assign miso_w = lb ? o_mosi : miso_drv;

  int checks = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Acts as an SPI slave: launches mb MSB first on the non-sampling sck edge,
  // records mosi on the sampling edge, and measures frame timing.
  task automatic run_frame(input string nm, input int s, input logic [31:0] dv, input int c,
                           input logic l, input logic [31:0] mb, input logic [31:0] eod);
    int dw, dvd, gp, busy_n, lo_n, falls, edges, first_idx, idx, pulses, mi, bad_ncs, bad_idle;
    logic cpol, cpha, prev_sck, prev_lo, lo, lead, trail, done;
    logic [31:0] mw, od_p;
    logic [63:0] msk;
    dw = p_dw[s]; dvd = p_div[s]; gp = p_gap[s]; cpol = p_cpol[s]; cpha = p_cpha[s];
    msk = (64'd1 << dw) - 64'd1;
    busy_n = 0; lo_n = 0; falls = 0; edges = 0; first_idx = -1; idx = 0; pulses = 0;
    mi = 0; bad_ncs = 0; bad_idle = 0; mw = '0; od_p = '0;
    prev_sck = cpol; prev_lo = 1'b0; done = 1'b0;
    sel = s; lb = l; miso_drv = 1'b0;
    @(posedge clk); #1;
    d32 = dv; ch = 2'(c); req[s] = 1'b1;
    @(posedge clk); #1;
    req[s] = 1'b0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      lo = (o_ncs != 3'b111);
      if (o_busy) busy_n++;
      if (lo) begin
        lo_n++;
        if (o_ncs != ~(3'b001 << c)) bad_ncs++;
        if (!prev_lo) begin
          falls++; idx = 0;
          if (!cpha) begin miso_drv = mb[dw-1]; mi = 1; end
        end else begin
          idx++;
        end
        lead  = (prev_sck == cpol) && (o_sck != cpol);
        trail = (prev_sck != cpol) && (o_sck == cpol);
        if (cpha ? trail : lead) begin
          edges++;
          if (edges == 1) first_idx = idx;
          mw = {mw[30:0], o_mosi};
        end
        if ((cpha ? lead : trail) && mi < dw) begin
          miso_drv = mb[dw-1-mi]; mi++;
        end
        req[s] = 1'($urandom_range(0, 1));
      end else begin
        if (o_sck != cpol || o_mosi != 1'b1) bad_idle++;
        req[s] = 1'b0;
      end
      if (o_nrx) begin pulses++; od_p = o_od; end
      prev_sck = o_sck; prev_lo = lo;
      if (busy_n > 0 && !o_busy) done = 1'b1;
    end
    req[s] = 1'b0;
    chk({nm, " finished"}, 32'(done), 32'd1);
    chk({nm, " busy_cycles"}, busy_n, dw * dvd + dvd + gp);
    chk({nm, " ncs_low_cycles"}, lo_n, dw * dvd + dvd);
    chk({nm, " frames"}, falls, 1);
    chk({nm, " sample_edges"}, edges, dw);
    chk({nm, " first_edge_at"}, first_idx, dvd);
    chk({nm, " mosi_word"}, mw, dv & msk[31:0]);
    chk({nm, " rx_pulses"}, pulses, 1);
    chk({nm, " odata_at_pulse"}, od_p, eod);
    chk({nm, " odata_held"}, o_od, eod);
    chk({nm, " wrong_cs_low"}, bad_ncs, 0);
    chk({nm, " idle_lines"}, bad_idle, 0);
  endtask

  task automatic run_ignored(input string nm, input int s, input int c);
    int viol;
    viol = 0; sel = s;
    @(posedge clk); #1;
    ch = 2'(c); req[s] = 1'b1;
    @(posedge clk); #1;
    req[s] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy || o_ncs != 3'b111) viol++;
    end
    chk(nm, viol, 0);
  endtask

  typedef struct {
    int          s;
    logic [31:0] dv;
    int          c;
    logic        l;
    logic [31:0] mb;
    logic [31:0] eod;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n, pulses, falls, hi, gok, gbad;
    logic prev, lo, prev_lo;
    tbl[0] = '{0, 32'hA5C3, 0, 1'b1, 32'h0,    32'hA5C3};
    tbl[1] = '{0, 32'h0F0F, 1, 1'b1, 32'h0,    32'h0F0F};
    tbl[2] = '{1, 32'h1234, 0, 1'b0, 32'hFFFF, 32'hFFFF};
    tbl[3] = '{2, 32'h0800, 0, 1'b0, 32'h0,    32'h0};
    tbl[4] = '{3, 32'h005A, 2, 1'b0, 32'h3C,   32'h3C};
    tbl[5] = '{2, 32'h0FFF, 1, 1'b0, 32'hA5A,  32'hA5A};

    #2 reset = 1'b1;
    #1;
    chk("rst_ncs0", 32'(ncs0), 32'h3);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_mosi0", 32'(mosi0), 1);
    chk("rst_sck0", 32'(sck0), 0);
    chk("rst_sck1_cpol", 32'(sck1), 1);
    chk("rst_odata0", 32'(od0), 0);
    chk("rst_nrx0", 32'(nrx0), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].s, tbl[i].dv, tbl[i].c, tbl[i].l,
                tbl[i].mb, tbl[i].eod);

    run_ignored("ignore_chan3_ncs3", 3, 3);

    for (int k = 0; k < 8; k++) begin
      int s, c, dw;
      logic [31:0] dv, mb, m;
      s = int'($urandom_range(0, 3)); dw = p_dw[s];
      c = int'($urandom_range(0, p_ncs[s] - 1));
      m = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
      dv = $urandom & m; mb = $urandom;
      run_frame($sformatf("rand%0d", k), s, dv, c, 1'b0, mb, mb & m);
    end

    // Reset in the middle of a frame on the default instance.
    sel = 0; lb = 1'b0; miso_drv = 1'b1;
    @(posedge clk); #1;
    d32 = 32'h1234; ch = 2'd0; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    n = 0; prev = 1'b0;
    for (int cyc = 0; cyc < 500 && n < 7; cyc++) begin
      @(negedge clk);
      if (!prev && sck0) n++;
      prev = sck0;
    end
    chk("midrst_reached_bit7", n, 7);
    #2 reset = 1'b1;
    #1;
    chk("midrst_sck", 32'(sck0), 0);
    chk("midrst_mosi", 32'(mosi0), 1);
    chk("midrst_ncs", 32'(ncs0), 32'h3);
    chk("midrst_busy", 32'(busy0), 0);
    chk("midrst_odata", 32'(od0), 0);
    pulses = 0;
    repeat (3) begin @(negedge clk); if (nrx0) pulses++; end
    reset = 1'b0;
    repeat (200) begin @(negedge clk); if (nrx0 || busy0) pulses++; end
    chk("midrst_no_activity", pulses, 0);
    run_frame("after_reset", 0, 32'hC0DE, 0, 1'b1, 32'h0, 32'hC0DE);

    // Request held high: back-to-back frames separated by CS_GAP.
    sel = 0; lb = 1'b1;
    @(posedge clk); #1;
    d32 = 32'h5AA5; ch = 2'd0; req[0] = 1'b1;
    falls = 0; pulses = 0; hi = 0; gok = 0; gbad = 0; prev_lo = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (cyc == 400) req[0] = 1'b0;
      lo = (ncs0 != 2'b11);
      if (lo && !prev_lo) begin
        if (falls > 0) begin
          if (hi == 2) gok++; else gbad++;
        end
        falls++; hi = 0;
      end
      if (!lo) hi++;
      if (nrx0) pulses++;
      prev_lo = lo;
    end
    chk("b2b_frames", falls, 3);
    chk("b2b_pulses", pulses, 3);
    chk("b2b_gaps_ok", gok, 2);
    chk("b2b_gaps_bad", gbad, 0);
    chk("b2b_odata", 32'(od0), 32'h5AA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
